// File: rtl/sp1_s.sv
// SPI slave (mode: sample and shift on sclk falling edge) with tx buffer and rx holding register.
// Optional overrun flag enabled by defining SP1_S_OVERRUN_DET_EN.
module sp1_s #(
    parameter int          SYNC_STAGES = 2,
    parameter logic [7:0]  IDLE_BYTE   = 8'h00
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sclk,
    input  logic       ss,
    input  logic       mosi,
    output logic       miso,
    input  logic [7:0] tx_data,
    input  logic       tx_load,
    output logic       tx_ready,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ack,
    output logic       busy_s
`ifdef SP1_S_OVERRUN_DET_EN
    ,
    output logic       rx_overrun
`endif
);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t state, state_nxt;

    logic [SYNC_STAGES-1:0] sclk_sync;
    logic [SYNC_STAGES-1:0] ss_sync;
    logic [SYNC_STAGES-1:0] mosi_sync;
    logic [SYNC_STAGES-1:0] fill;

    logic       sclk_s, ss_s, mosi_s;
    logic       sclk_d, fall, fall_p, mosi_q;
    logic       armed;
    logic [2:0] cnt;
    logic [7:0] tx_sr, rx_sr, tx_buf, tx_next;
    logic       tx_full;
    logic       start, stop, shift, wrap, consume;

    assign sclk_s  = sclk_sync[SYNC_STAGES-1];
    assign ss_s    = ss_sync[SYNC_STAGES-1];
    assign mosi_s  = mosi_sync[SYNC_STAGES-1];
    assign fall    = sclk_d & ~sclk_s;
    assign tx_next = tx_full ? tx_buf : IDLE_BYTE;
    assign consume = start | wrap;

    assign miso     = (state == SHIFT) ? tx_sr[7] : 1'b0;
    assign tx_ready = ~tx_full;
    assign busy_s   = (state == SHIFT) && (cnt != 3'd0);

    // Synchronisers; armed blocks a start until ss is seen high after reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_sync <= '0;
            ss_sync   <= '1;
            mosi_sync <= '0;
            fill      <= '0;
            sclk_d    <= 1'b0;
            fall_p    <= 1'b0;
            mosi_q    <= 1'b0;
            armed     <= 1'b0;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
            ss_sync   <= {ss_sync[SYNC_STAGES-2:0], ss};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
            fill      <= {fill[SYNC_STAGES-2:0], 1'b1};
            sclk_d    <= sclk_s;
            fall_p    <= fall;
            mosi_q    <= mosi_s;
            armed     <= armed | ((&fill) & ss_s);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        start     = 1'b0;
        stop      = 1'b0;
        shift     = 1'b0;
        wrap      = 1'b0;
        unique case (state)
            IDLE: begin
                if (armed && !ss_s) begin
                    state_nxt = SHIFT;
                    start     = 1'b1;
                end
            end
            SHIFT: begin
                if (ss_s) begin
                    state_nxt = IDLE;
                    stop      = 1'b1;
                end else if (fall_p) begin
                    shift = 1'b1;
                    wrap  = (cnt == 3'd7);
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt   <= 3'd0;
            tx_sr <= 8'h00;
            rx_sr <= 8'h00;
        end else if (start || stop) begin
            cnt   <= 3'd0;
            tx_sr <= start ? tx_next : 8'h00;
            rx_sr <= 8'h00;
        end else if (shift) begin
            cnt   <= cnt + 3'd1;
            tx_sr <= wrap ? tx_next : {tx_sr[6:0], 1'b0};
            rx_sr <= {rx_sr[6:0], mosi_q};
        end
    end

    // A load in the same cycle as consumption is dropped
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_full <= 1'b0;
            tx_buf  <= 8'h00;
        end else if (consume) begin
            tx_full <= 1'b0;
        end else if (tx_load && !tx_full) begin
            tx_full <= 1'b1;
            tx_buf  <= tx_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_data  <= 8'h00;
            rx_valid <= 1'b0;
        end else if (wrap) begin
            rx_data  <= {rx_sr[6:0], mosi_q};
            rx_valid <= 1'b1;
        end else if (rx_ack) begin
            rx_valid <= 1'b0;
        end
    end

`ifdef SP1_S_OVERRUN_DET_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                            rx_overrun <= 1'b0;
        else if (wrap && rx_valid && !rx_ack)  rx_overrun <= 1'b1;
        else if (rx_ack)                       rx_overrun <= 1'b0;
    end
`endif

endmodule

// File: tb/tb_sp1_s.sv
// Self-checking bench for sp1_s: SPI master model, rx scoreboard and miso checks.
module tb_sp1_s;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       sclk, ss, mosi, miso;
    logic [7:0] tx_data;
    logic       tx_load, tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid, rx_ack, busy_s;
`ifdef SP1_S_OVERRUN_DET_EN
    logic       rx_overrun;
`endif

    int checks = 0;
    int fails  = 0;
    bit auto_ack = 1'b1;
    logic [7:0] exp_rx[$];
    logic [7:0] got;

    always #5 clk = ~clk;

    sp1_s #(.SYNC_STAGES(2), .IDLE_BYTE(8'h00)) dut (
        .clk(clk), .rst_n(rst_n), .sclk(sclk), .ss(ss), .mosi(mosi),
        .miso(miso), .tx_data(tx_data), .tx_load(tx_load),
        .tx_ready(tx_ready), .rx_data(rx_data), .rx_valid(rx_valid),
        .rx_ack(rx_ack), .busy_s(busy_s)
`ifdef SP1_S_OVERRUN_DET_EN
        , .rx_overrun(rx_overrun)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            fails++;
            $display("FAIL %s got=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    task automatic load(input logic [7:0] d);
        @(negedge clk);
        tx_data = d;
        tx_load = 1'b1;
        @(negedge clk);
        tx_load = 1'b0;
    endtask

    task automatic ss_low();
        @(negedge clk);
        ss = 1'b0;
        repeat (8) @(negedge clk);
    endtask

    task automatic ss_high();
        repeat (8) @(negedge clk);
        ss = 1'b1;
        repeat (8) @(negedge clk);
    endtask

    // Master sets mosi on sclk rise, samples miso at the rise; slave acts on fall
    task automatic xfer(input logic [7:0] mo, input int nbits, input bit lat,
                        output logic [7:0] mi);
        logic [7:0] m;
        m = 8'h00;
        for (int i = 0; i < nbits; i++) begin
            repeat (8) @(negedge clk);
            mosi = mo[7-i];
            sclk = 1'b1;
            m = {m[6:0], miso};
            repeat (8) @(negedge clk);
            sclk = 1'b0;
        end
        if (lat) begin
            repeat (3) @(negedge clk);
            chk("lat_early", {31'd0, rx_valid}, 32'd0);
            @(negedge clk);
            chk("lat_exact", {31'd0, rx_valid}, 32'd1);
        end
        mi = m;
    endtask

    // Scoreboard consumer: pops expected byte on each rx_valid and acks it
    initial begin
        forever begin
            @(negedge clk);
            if (auto_ack && rx_valid && !rx_ack) begin
                if (exp_rx.size() == 0) chk("rx_unexpected", {24'd0, rx_data}, 32'hFFFF_FFFF);
                else chk("rx_data", {24'd0, rx_data}, {24'd0, exp_rx.pop_front()});
                rx_ack = 1'b1;
                @(negedge clk);
                rx_ack = 1'b0;
            end
        end
    end

    initial begin
        rst_n = 1'b0; ss = 1'b1; sclk = 1'b0; mosi = 1'b0;
        tx_data = 8'h00; tx_load = 1'b0; rx_ack = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_miso", {31'd0, miso}, 32'd0);
        chk("rst_tx_ready", {31'd0, tx_ready}, 32'd1);
        chk("rst_rx_valid", {31'd0, rx_valid}, 32'd0);
        chk("rst_rx_data", {24'd0, rx_data}, 32'd0);
        chk("rst_busy", {31'd0, busy_s}, 32'd0);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);

        // Preloaded byte out, 3C in, with rx_valid latency
        load(8'hA5);
        chk("t1_tx_ready_full", {31'd0, tx_ready}, 32'd0);
        exp_rx.push_back(8'h3C);
        ss_low();
        chk("t1_tx_ready_cons", {31'd0, tx_ready}, 32'd1);
        xfer(8'h3C, 8, 1'b1, got);
        chk("t1_miso", {24'd0, got}, 32'hA5);
        chk("t1_busy_after", {31'd0, busy_s}, 32'd0);
        ss_high();
        chk("t1_miso_idle", {31'd0, miso}, 32'd0);

        // No preload: idle byte out
        exp_rx.push_back(8'hFF);
        ss_low();
        xfer(8'hFF, 8, 1'b0, got);
        chk("t2_miso", {24'd0, got}, 32'h00);
        ss_high();

        // Back-to-back bytes with buffer reload in between
        load(8'h9A);
        exp_rx.push_back(8'h12);
        exp_rx.push_back(8'h34);
        ss_low();
        chk("t3_ready_pre", {31'd0, tx_ready}, 32'd1);
        load(8'h56);
        chk("t3_ready_full", {31'd0, tx_ready}, 32'd0);
        xfer(8'h12, 8, 1'b0, got);
        chk("t3_miso0", {24'd0, got}, 32'h9A);
        xfer(8'h34, 8, 1'b0, got);
        chk("t3_miso1", {24'd0, got}, 32'h56);
        chk("t3_ready_end", {31'd0, tx_ready}, 32'd1);
        ss_high();

        // Abort after 4 bits
        load(8'hBB);
        ss_low();
        xfer(8'hF0, 4, 1'b0, got);
        repeat (4) @(negedge clk);
        chk("t4_busy_mid", {31'd0, busy_s}, 32'd1);
        ss_high();
        chk("t4_rx_valid", {31'd0, rx_valid}, 32'd0);
        chk("t4_rx_data", {24'd0, rx_data}, 32'h34);
        chk("t4_tx_ready", {31'd0, tx_ready}, 32'd1);
        chk("t4_miso", {31'd0, miso}, 32'd0);
        chk("t4_busy", {31'd0, busy_s}, 32'd0);
        load(8'h5A);
        exp_rx.push_back(8'h81);
        ss_low();
        xfer(8'h81, 8, 1'b0, got);
        chk("t4_miso_next", {24'd0, got}, 32'h5A);
        ss_high();

        // Two bytes without ack
        repeat (4) @(negedge clk);
        auto_ack = 1'b0;
        ss_low();
        xfer(8'h11, 8, 1'b0, got);
        xfer(8'h22, 8, 1'b0, got);
        repeat (4) @(negedge clk);
        chk("t5_rx_data", {24'd0, rx_data}, 32'h22);
        chk("t5_rx_valid", {31'd0, rx_valid}, 32'd1);
`ifdef SP1_S_OVERRUN_DET_EN
        chk("t5_overrun", {31'd0, rx_overrun}, 32'd1);
`endif
        rx_ack = 1'b1;
        @(negedge clk);
        rx_ack = 1'b0;
        @(negedge clk);
        chk("t5_valid_clr", {31'd0, rx_valid}, 32'd0);
`ifdef SP1_S_OVERRUN_DET_EN
        chk("t5_overrun_clr", {31'd0, rx_overrun}, 32'd0);
`endif
        ss_high();
        auto_ack = 1'b1;

        // Reset mid-byte, then a clean transfer
        load(8'h77);
        ss_low();
        xfer(8'hC3, 3, 1'b0, got);
        repeat (4) @(negedge clk);
        chk("t6_busy_pre", {31'd0, busy_s}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("t6_miso", {31'd0, miso}, 32'd0);
        chk("t6_tx_ready", {31'd0, tx_ready}, 32'd1);
        chk("t6_rx_data", {24'd0, rx_data}, 32'd0);
        chk("t6_rx_valid", {31'd0, rx_valid}, 32'd0);
        chk("t6_busy", {31'd0, busy_s}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        xfer(8'hFF, 2, 1'b0, got);
        repeat (4) @(negedge clk);
        chk("t6_stay_idle", {31'd0, busy_s}, 32'd0);
        chk("t6_idle_miso", {31'd0, miso}, 32'd0);
        ss_high();
        load(8'h3C);
        exp_rx.push_back(8'hC3);
        ss_low();
        xfer(8'hC3, 8, 1'b0, got);
        chk("t6_miso_after", {24'd0, got}, 32'h3C);
        ss_high();

        repeat (10) @(negedge clk);
        chk("rx_pending", exp_rx.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
